// File: rtl/rca_pkg.sv
// Shared types and sizing constants for the bit-serial ripple-carry subtractor.
package rca_pkg;

  localparam int RCA_WIDTH = 4;
  localparam int RCA_CNT_W = $clog2(RCA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor_1bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/rca_serial_subtractor.sv
// Bit-serial inverse of the ripple-carry adder: recovers A = Q - B - Cin, LSB first.
// Optional range flag on err is built only when RCA_SERIAL_SUB_RANGE_CHECK_EN is defined.
module rca_serial_subtractor
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH:0]   Q,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] A,
  output logic             busy,
  output logic             valid,
  output logic             err
);

  localparam int CNT_W = (WIDTH == RCA_WIDTH) ? RCA_CNT_W : $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH:0]   q_sr;
  logic [WIDTH:0]   b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH:0]   res_next;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic             d_bit;
  logic             bout;
  logic             last_bit;

  full_subtractor_1bit u_fsub (
    .x   (q_sr[0]),
    .y   (b_sr[0]),
    .bin (borrow),
    .d   (d_bit),
    .bout(bout)
  );

  // res_sr keeps the upper WIDTH bits seen so far; on the final bit the full difference is res_next.
  assign res_next = {d_bit, res_sr};
  assign last_bit = (cnt == CNT_W'(WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == SHIFT);
    valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      A      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            q_sr   <= Q;
            b_sr   <= {1'b0, B};
            res_sr <= '0;
            cnt    <= '0;
            borrow <= Cin;
          end
        end
        SHIFT: begin
          q_sr   <= q_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next[WIDTH:1];
          borrow <= bout;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            A <= res_next[WIDTH-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef RCA_SERIAL_SUB_RANGE_CHECK_EN
  logic err_q;

  // A negative difference leaves a borrow; an over-wide one sets the top difference bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == SHIFT && last_bit) begin
      err_q <= bout | res_next[WIDTH];
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
